// File: rtl/aes_key_expand.sv
// AES key schedule: latches a cipher key and expands it one word per cycle into a round-key array.
// Define AES_KEYEXP_LONG_EN to add AES-192/256 support; otherwise only AES-128 is built.
module aes_key_expand #(
`ifdef AES_KEYEXP_LONG_EN
   parameter int MAX_WORDS = 60
`else
   parameter int MAX_WORDS = 44
`endif
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         init,
   input  logic [255:0] key,
   input  logic [1:0]   keylen,
   input  logic [3:0]   round,
   output logic [127:0] round_key,
   output logic [3:0]   round_num,
   output logic         key_ready,
   output logic         busy
);

`ifdef AES_KEYEXP_LONG_EN
   localparam int KW     = 256;
   localparam int MW     = 3;
   localparam int NK_MAX = 8;
`else
   localparam int KW     = 128;
   localparam int MW     = 2;
   localparam int NK_MAX = 4;
`endif

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {IDLE, LOAD, EXPAND, READY} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [31:0]   w [MAX_WORDS];
   logic [KW-1:0] key_q;
   logic [5:0]    idx;
   logic [MW-1:0] m;
   logic [MW-1:0] m_max;
   logic [7:0]    rcon;
   logic [5:0]    nk;
   logic [3:0]    nr;
   logic [5:0]    tot_m1;
   logic          do_load;
   logic          do_expand;
   logic          last_word;
   logic [31:0]   prev;
   logic [31:0]   temp;
   logic [31:0]   new_word;
   logic [5:0]    rbase;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] pos;
      pos = 11'd2047 - {b, 3'b000};
      return SBOX_TBL[pos -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

`ifdef AES_KEYEXP_LONG_EN
   logic [1:0] keylen_q;

   // Key geometry follows the keylen latched with the key; reserved code 3 falls back to AES-128.
   always_comb begin
      nk    = 6'd4;
      nr    = 4'd10;
      m_max = 3'd3;
      case (keylen_q)
         2'd1: begin
            nk    = 6'd6;
            nr    = 4'd12;
            m_max = 3'd5;
         end
         2'd2: begin
            nk    = 6'd8;
            nr    = 4'd14;
            m_max = 3'd7;
         end
         default: ;
      endcase
   end
`else
   logic unused_inputs;

   assign nk            = 6'd4;
   assign nr            = 4'd10;
   assign m_max         = 2'd3;
   assign round_num     = 4'd10;
   assign unused_inputs = ^{key[127:0], keylen};
`endif

   assign tot_m1 = {nr, 2'b11};
   assign busy   = (state == LOAD) || (state == EXPAND);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // A new init always wins: it restarts from LOAD and suppresses whatever the current state would do.
   always_comb begin
      state_nxt = state;
      do_load   = 1'b0;
      do_expand = 1'b0;
      last_word = 1'b0;
      case (state)
         IDLE:   if (init) state_nxt = LOAD;
         LOAD: begin
            do_load   = 1'b1;
            state_nxt = EXPAND;
         end
         EXPAND: begin
            do_expand = 1'b1;
            last_word = (idx == tot_m1);
            if (last_word) state_nxt = READY;
         end
         READY:  if (init) state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
      if (init) begin
         state_nxt = LOAD;
         do_load   = 1'b0;
         do_expand = 1'b0;
         last_word = 1'b0;
      end
   end

   always_comb begin
      prev = w[idx - 6'd1];
      temp = prev;
      if (m == '0) temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
`ifdef AES_KEYEXP_LONG_EN
      else if (nk == 6'd8 && m == 3'd4) temp = sub_word(prev);
`endif
      new_word = w[idx - nk] ^ temp;
   end

   // The m counter tracks i mod Nk without a divider; Rcon advances once per Nk words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < MAX_WORDS; k++) w[k] <= '0;
         key_q     <= '0;
         idx       <= '0;
         m         <= '0;
         rcon      <= 8'h01;
         key_ready <= 1'b0;
`ifdef AES_KEYEXP_LONG_EN
         keylen_q  <= 2'd0;
         round_num <= 4'd10;
`endif
      end else begin
         if (init) begin
            key_q     <= key[255 -: KW];
            key_ready <= 1'b0;
`ifdef AES_KEYEXP_LONG_EN
            keylen_q  <= keylen;
`endif
         end
         if (do_load) begin
            for (int k = 0; k < NK_MAX; k++) begin
               if (k < int'(nk)) w[k] <= key_q[KW-1-32*k -: 32];
            end
            idx  <= nk;
            m    <= '0;
            rcon <= 8'h01;
`ifdef AES_KEYEXP_LONG_EN
            round_num <= nr;
`endif
         end
         if (do_expand) begin
            w[idx] <= new_word;
            idx    <= idx + 6'd1;
            m      <= (m == m_max) ? '0 : m + 1'b1;
            if (m == '0) rcon <= xtime(rcon);
            if (last_word) key_ready <= 1'b1;
         end
      end
   end

   assign rbase = {round, 2'b00};

   // Combinational lookup so the key tracks round within the same cycle.
   always_comb begin
      round_key = '0;
      if (key_ready && (round <= round_num))
         round_key = {w[rbase], w[rbase + 6'd1], w[rbase + 6'd2], w[rbase + 6'd3]};
   end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key-expansion vectors.
module tb_aes_key_expand;

   logic         clk = 1'b0;
   logic         rst;
   logic         init;
   logic [255:0] key;
   logic [1:0]   keylen;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [3:0]   round_num;
   logic         key_ready;
   logic         busy;

   int n_vec  = 0;
   int n_miss = 0;

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] JUNK      = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [255:0] K192      = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256      = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   typedef struct {
      logic [1:0]   keylen;
      logic [255:0] key;
      int           latency;
      logic [3:0]   nr;
      logic [127:0] r0;
      logic [3:0]   mid_round;
      logic [127:0] mid;
      logic [127:0] last;
   } vec_t;

   vec_t vecs[4];

   aes_key_expand dut (
      .clk       (clk),
      .rst       (rst),
      .init      (init),
      .key       (key),
      .keylen    (keylen),
      .round     (round),
      .round_key (round_key),
      .round_num (round_num),
      .key_ready (key_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Pulses init for one edge, then scrambles key/keylen to show they are ignored afterwards.
   task automatic applyStimulus(input logic [1:0] kl, input logic [255:0] k);
      @(negedge clk);
      key    = k;
      keylen = kl;
      init   = 1'b1;
      @(posedge clk);
      #1;
      init   = 1'b0;
      key    = ~k;
      keylen = kl ^ 2'b01;
   endtask

   task automatic wait_ready(output int edges);
      edges = 0;
      while (!key_ready && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic read_round(input logic [3:0] r, output logic [127:0] rk);
      @(negedge clk);
      round = r;
      #1;
      rk = round_key;
   endtask

   initial begin
      int           edges;
      logic [127:0] rk;

      rst    = 1'b1;
      init   = 1'b0;
      key    = '0;
      keylen = 2'd0;
      round  = 4'd0;

      vecs[0] = '{2'd0, {FIPS_KEY, 128'h0}, 41, 4'd10, FIPS_KEY, 4'd1, FIPS_R1, FIPS_R10};
      vecs[1] = '{2'd3, {FIPS_KEY, JUNK},   41, 4'd10, FIPS_KEY, 4'd1, FIPS_R1, FIPS_R10};
`ifdef AES_KEYEXP_LONG_EN
      vecs[2] = '{2'd1, K192, 47, 4'd12, 128'h8e73b0f7da0e6452c810f32b809079e5,
                  4'd1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5,
                  128'he98ba06f448c773c8ecc720401002202};
      vecs[3] = '{2'd2, K256, 53, 4'd14, 128'h603deb1015ca71be2b73aef0857d7781,
                  4'd3, 128'ha8b09c1a93d194cdbe49846eb75d5b9a,
                  128'hfe4890d1e6188d0b046df344706c631e};
`else
      vecs[2] = '{2'd1, {FIPS_KEY, JUNK},   41, 4'd10, FIPS_KEY, 4'd1, FIPS_R1, FIPS_R10};
      vecs[3] = '{2'd2, {FIPS_KEY, ~JUNK},  41, 4'd10, FIPS_KEY, 4'd1, FIPS_R1, FIPS_R10};
`endif

      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset key_ready", 128'(key_ready), 128'd0);
      checkOutput("reset busy",      128'(busy),      128'd0);
      checkOutput("reset round_num", 128'(round_num), 128'd10);
      checkOutput("reset round_key", round_key,       128'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 4; v++) begin
         applyStimulus(vecs[v].keylen, vecs[v].key);
         checkOutput($sformatf("v%0d busy after init", v), 128'(busy), 128'd1);
         checkOutput($sformatf("v%0d ready after init", v), 128'(key_ready), 128'd0);
         wait_ready(edges);
         checkOutput($sformatf("v%0d latency", v), 128'(edges), 128'(vecs[v].latency));
         checkOutput($sformatf("v%0d busy when ready", v), 128'(busy), 128'd0);
         checkOutput($sformatf("v%0d round_num", v), 128'(round_num), 128'(vecs[v].nr));
         read_round(4'd0, rk);
         checkOutput($sformatf("v%0d round 0", v), rk, vecs[v].r0);
         read_round(vecs[v].mid_round, rk);
         checkOutput($sformatf("v%0d round mid", v), rk, vecs[v].mid);
         read_round(vecs[v].nr, rk);
         checkOutput($sformatf("v%0d round last", v), rk, vecs[v].last);
         read_round(vecs[v].nr + 4'd1, rk);
         checkOutput($sformatf("v%0d round beyond Nr", v), rk, 128'd0);
      end

      // Restart mid-expansion: the zero-key run is abandoned in favour of the FIPS key.
      applyStimulus(2'd0, 256'd0);
      repeat (20) @(posedge clk);
      #1;
      checkOutput("abort ready before restart", 128'(key_ready), 128'd0);
      checkOutput("abort busy before restart",  128'(busy),      128'd1);
      applyStimulus(2'd0, {FIPS_KEY, 128'h0});
      wait_ready(edges);
      checkOutput("abort latency", 128'(edges), 128'd41);
      read_round(4'd10, rk);
      checkOutput("abort round 10", rk, FIPS_R10);
      read_round(4'd1, rk);
      checkOutput("abort round 1", rk, FIPS_R1);

      // Re-init from READY hides the old schedule, then an async reset lands between edges.
      read_round(4'd10, rk);
      applyStimulus(2'd0, 256'd0);
      checkOutput("reinit ready drops", 128'(key_ready), 128'd0);
      checkOutput("reinit round_key hidden", round_key, 128'd0);
      repeat (10) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async rst key_ready", 128'(key_ready), 128'd0);
      checkOutput("async rst busy",      128'(busy),      128'd0);
      checkOutput("async rst round_key", round_key,       128'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("idle after rst ready", 128'(key_ready), 128'd0);
      applyStimulus(2'd0, {FIPS_KEY, 128'h0});
      wait_ready(edges);
      checkOutput("post rst latency", 128'(edges), 128'd41);
      read_round(4'd10, rk);
      checkOutput("post rst round 10", rk, FIPS_R10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Key-schedule stage directly upstream of the AES encipher datapath.
- Latches a cipher key and expands it, one 32-bit word per cycle, into the full round-key schedule held in an internal word array.
- Drives key_ready, round_num and round_key to the encipher. The encipher indexes the schedule by its round output and receives the matching 128-bit round key combinationally.

Parameters:
- MAX_WORDS, 60, depth of the word array (4*(14+1)); 44 when long keys are compiled out.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- init  input  1  single-cycle pulse: latch key/keylen and start expansion.
- key  input  256  cipher key, left-aligned: AES-128 uses [255:128], AES-192 uses [255:64], AES-256 uses [255:0].
- keylen  input  2  0=AES-128, 1=AES-192, 2=AES-256, 3=reserved (treated as 0).
- round  input  4  round index requested by the encipher.
- round_key  output  128  {w[4r],w[4r+1],w[4r+2],w[4r+3]}, where r=round and w[4r] occupies [127:96].
- round_num  output  4  Nr: 10/12/14.
- key_ready  output  1  schedule complete and valid.
- busy  output  1  high in LOAD or EXPAND.

Behaviour:
- Reset: clk is the only clock; rst is asynchronous, active-high. It clears state to IDLE, key_ready=0, busy=0, round_num=10, all words=0 and the Rcon register=8'h01.
- Nk and Nr by keylen:
  - AES-128: Nk=4, Nr=10.
  - AES-192: Nk=6, Nr=12.
  - AES-256: Nk=8, Nr=14.
  - Total words Tot=4*(Nr+1): 44/52/60.
- States: IDLE, LOAD, EXPAND, READY.
  - IDLE -> LOAD on init.
  - LOAD: writes w[0..Nk-1] from key in one cycle. Sets word index i=Nk, modulo counter m=0, Rcon=01. Goes to EXPAND.
  - EXPAND: writes w[i] each cycle. When i==Tot-1 is written, sets key_ready=1 and goes to READY.
  - READY -> LOAD on init.
  - round_num is registered in LOAD.
- Word generation, with t=w[i-1]:
  - If m==0: t=SubWord(RotWord(t)) ^ {Rcon,24'h0}, then Rcon=xtime(Rcon), i.e. 01,02,...,80,1b,36.
  - Else if Nk==8 and m==4: t=SubWord(t).
  - w[i]=w[i-Nk]^t.
  - m increments and wraps at Nk-1. No division or modulo operator is used.
- SubWord uses a combinational byte S-box, shared by all four bytes.
- Latency: with init sampled at edge E0, key_ready is high after edge E(1+Tot-Nk), i.e. E41, E47 or E53 for AES-128/192/256.
- key_ready and busy:
  - key_ready drops to 0 on the edge that samples init.
  - busy=1 from that edge until key_ready rises.
- round_key:
  - Combinational mux of the word array.
  - Forced to 0 when key_ready=0 or round>round_num.
  - round_key therefore changes in the same cycle as round, which the encipher requires (it XORs round_key in the cycle round updates).
- init while busy: aborts the current expansion and restarts from LOAD with the new key/keylen. Partially written words are overwritten.
- init in READY: key_ready=0 from the next cycle. The old schedule is not visible.
- Inputs are sampled only in the init cycle. key/keylen changes at any other time are ignored.
- keylen=3 behaves exactly as keylen=0.
- Reset mid-expansion returns to IDLE immediately. The next init is required before key_ready.

Optional Feature:
- Macro: AES_KEYEXP_LONG_EN.
- Defined: AES-192/256 are supported as above, MAX_WORDS=60.
- Undefined:
  - keylen is ignored and always treated as AES-128.
  - Word array is 44 words, round_num is constant 10.
  - The Nk==8 SubWord branch and the m counter wider than 2 bits are removed.
  - Latency is always 41 cycles.

Test Plan:
- keylen=0, key[255:128]=2b7e151628aed2a6abf7158809cf4f3c, init pulse -> key_ready rises after 41 edges; round=0 gives the key itself; round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; round_num=10.
- keylen=1, key[255:64]=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> key_ready after 47 edges; round=12 gives e98ba06f448c773c8ecc720401002202; round_num=12.
- keylen=2, key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> key_ready after 53 edges; round=14 gives fe4890d1e6188d0b046df344706c631e; round_num=14.
- AES-128 init, then second init (different key) 20 cycles later -> key_ready stays 0; after 41 edges from the second init, round 10 matches the second key's expected value.
- Key ready (AES-128), then round=11 -> round_key=0; keylen=3 -> identical to the keylen=0 results.
- rst asserted asynchronously mid-EXPAND (between clock edges) -> key_ready=0, busy=0, round_key=0 immediately; a fresh init then completes normally.
